// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared state, class, opcode and select encodings for the multi-cycle RV32I controller
package multicycle_ctrl_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [3:0] {C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC} cls_t;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] EXT_I = 3'd0;
  localparam logic [2:0] EXT_U = 3'd1;
  localparam logic [2:0] EXT_S = 3'd2;
  localparam logic [2:0] EXT_B = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller-to-datapath/memory signal bundle
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_req, ir_we, pc_we;
  logic [1:0]  pc_src;
  logic [2:0]  ext_op;
  logic        alu_a_sel, alu_b_sel, dmem_req, dmem_we, reg_we;
  logic [1:0]  wb_sel;
  logic        retire, trap;
  logic [1:0]  trap_cause;
  modport master (
    input  instr, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, pc_we, pc_src, ext_op, alu_a_sel, alu_b_sel,
           dmem_req, dmem_we, reg_we, wb_sel, retire, trap, trap_cause
  );
  modport slave (
    output instr, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, pc_we, pc_src, ext_op, alu_a_sel, alu_b_sel,
           dmem_req, dmem_we, reg_we, wb_sel, retire, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: opcode to instruction class, immediate format and illegal flag
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output cls_t       cls_o,
  output logic [2:0] ext_op_o,
  output logic       illegal_o
);
  always_comb begin
    cls_o = C_OP;
    ext_op_o = EXT_I;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP:     cls_o = C_OP;
      OPC_OPIMM:  cls_o = C_OPIMM;
      OPC_LOAD:   cls_o = C_LOAD;
      OPC_JALR:   cls_o = C_JALR;
      OPC_LUI:    begin cls_o = C_LUI;    ext_op_o = EXT_U; end
      OPC_AUIPC:  begin cls_o = C_AUIPC;  ext_op_o = EXT_U; end
      OPC_STORE:  begin cls_o = C_STORE;  ext_op_o = EXT_S; end
      OPC_BRANCH: begin cls_o = C_BRANCH; ext_op_o = EXT_B; end
      OPC_JAL:    begin cls_o = C_JAL;    ext_op_o = EXT_J; end
      default:    illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer with memory-wait timeout trap
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  multicycle_ctrl_if.master bus
);
  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls;
  logic [2:0]       ext_q, ext_d, dec_ext;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             dec_ill, timeout, br, st, unused_instr;
  multicycle_ctrl_decode u_dec (
    .opcode_i  (bus.instr[6:0]),
    .cls_o     (dec_cls),
    .ext_op_o  (dec_ext),
    .illegal_o (dec_ill)
  );
  assign unused_instr = ^bus.instr[31:7];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = cnt_inc >= CNT_W'(TIMEOUT_CYCLES);
  assign br = cls_q == C_BRANCH;
  assign st = cls_q == C_STORE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q <= C_OP;
      ext_q <= EXT_I;
      cause_q <= CAUSE_NONE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      ext_q <= ext_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
    end
  end
  // Outputs are forced quiet while rst_n is low so a reset abandons any request immediately.
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    ext_d = ext_q;
    cause_d = cause_q;
    cnt_d = '0;
    bus.imem_req = 1'b0;
    bus.ir_we = 1'b0;
    bus.pc_we = 1'b0;
    bus.pc_src = PC_PLUS4;
    bus.ext_op = EXT_I;
    bus.alu_a_sel = 1'b0;
    bus.alu_b_sel = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we = 1'b0;
    bus.reg_we = 1'b0;
    bus.wb_sel = WB_ALU;
    bus.retire = 1'b0;
    bus.trap = 1'b0;
    bus.trap_cause = CAUSE_NONE;
    if (rst_n) begin
      bus.ext_op = ext_q;
      bus.trap_cause = cause_q;
      case (state_q)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_we = bus.imem_ready;
          cnt_d = bus.imem_ready ? '0 : cnt_inc;
          state_d = bus.imem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
          cause_d = (!bus.imem_ready && timeout) ? CAUSE_IMEM : cause_q;
        end
        S_DECODE: begin
          cls_d = dec_cls;
          ext_d = dec_ext;
          state_d = dec_ill ? S_TRAP : S_EXEC;
          cause_d = dec_ill ? CAUSE_ILLEGAL : cause_q;
        end
        S_EXEC: begin
          bus.alu_a_sel = cls_q inside {C_AUIPC, C_BRANCH, C_JAL};
          bus.alu_b_sel = !(cls_q inside {C_OP, C_BRANCH});
          bus.pc_we = br;
          bus.retire = br;
          bus.pc_src = (br && bus.branch_taken) ? PC_IMM : PC_PLUS4;
          state_d = br ? S_FETCH : (cls_q inside {C_LOAD, C_STORE}) ? S_MEM : S_WB;
        end
        S_MEM: begin
          bus.dmem_req = 1'b1;
          bus.dmem_we = st;
          bus.pc_we = bus.dmem_ready && st;
          bus.retire = bus.dmem_ready && st;
          cnt_d = bus.dmem_ready ? '0 : cnt_inc;
          state_d = bus.dmem_ready ? (st ? S_FETCH : S_WB) : timeout ? S_TRAP : S_MEM;
          cause_d = (!bus.dmem_ready && timeout) ? CAUSE_DMEM : cause_q;
        end
        S_WB: begin
          bus.reg_we = 1'b1;
          bus.pc_we = 1'b1;
          bus.retire = 1'b1;
          bus.wb_sel = (cls_q == C_LOAD) ? WB_MEM : (cls_q inside {C_JAL, C_JALR}) ? WB_PC4 : WB_ALU;
          bus.pc_src = (cls_q == C_JAL) ? PC_IMM : (cls_q == C_JALR) ? PC_JALR : PC_PLUS4;
          state_d = S_FETCH;
        end
        S_TRAP: bus.trap = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the multi-cycle controller output sequence
module tb_multicycle_ctrl;
  typedef struct packed {
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] ext_op;
    logic       alu_a_sel, alu_b_sel, dmem_req, dmem_we, reg_we;
    logic [1:0] wb_sel;
    logic       retire, trap;
    logic [1:0] trap_cause;
  } outs_t;
  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  int n_ret = 0;
  int n_pcw = 0;
  outs_t got, e;
  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign got = {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_src, bus.ext_op, bus.alu_a_sel,
                bus.alu_b_sel, bus.dmem_req, bus.dmem_we, bus.reg_we, bus.wb_sel, bus.retire,
                bus.trap, bus.trap_cause};
  always @(posedge clk) begin
    if (bus.retire) n_ret <= n_ret + 1;
    if (bus.pc_we) n_pcw <= n_pcw + 1;
  end
  function automatic outs_t z(input logic [2:0] x);
    outs_t r;
    r = '0;
    r.ext_op = x;
    return r;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input outs_t exp);
    #1;
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic chk_n(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic fetch(input string tag, input logic [31:0] w, input logic [2:0] x);
    outs_t f;
    bus.instr = w;
    bus.imem_ready = 1'b1;
    f = z(x);
    f.imem_req = 1'b1;
    f.ir_we = 1'b1;
    chk(tag, f);
    cyc();
    bus.imem_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.instr = '0;
    bus.branch_taken = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    cyc();
    chk("reset", z(0));
    rst_n = 1'b1;
    e = z(0); e.imem_req = 1'b1; chk("fetch_wait", e);
    fetch("ori_fetch", 32'h07b5e513, 0);
    chk("ori_decode", z(0)); cyc();
    e = z(0); e.alu_b_sel = 1'b1; chk("ori_exec", e); cyc();
    e = z(0); e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; chk("ori_wb", e); cyc();
    chk_n("ori_retire", n_ret, 1);
    fetch("lui_fetch", 32'h02710637, 0);
    chk("lui_decode", z(0)); cyc();
    e = z(1); e.alu_b_sel = 1'b1; chk("lui_exec", e); cyc();
    e = z(1); e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; chk("lui_wb", e); cyc();
    fetch("sw_fetch", 32'hf863ae23, 1);
    chk("sw_decode", z(1)); cyc();
    e = z(2); e.alu_b_sel = 1'b1; chk("sw_exec", e); cyc();
    bus.dmem_ready = 1'b1;
    e = z(2); e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; chk("sw_mem", e); cyc();
    bus.dmem_ready = 1'b0;
    chk_n("sw_retire", n_ret, 3);
    fetch("swd_fetch", 32'hf863ae23, 2);
    chk("swd_decode", z(2)); cyc();
    e = z(2); e.alu_b_sel = 1'b1; chk("swd_exec", e); cyc();
    for (int i = 0; i < 3; i++) begin
      e = z(2); e.dmem_req = 1'b1; e.dmem_we = 1'b1; chk("swd_wait", e); cyc();
    end
    bus.dmem_ready = 1'b1;
    e = z(2); e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; chk("swd_done", e); cyc();
    bus.dmem_ready = 1'b0;
    chk_n("swd_retire", n_ret, 4);
    fetch("beq1_fetch", 32'hfe7308e3, 2);
    chk("beq1_decode", z(2)); cyc();
    bus.branch_taken = 1'b1;
    e = z(3); e.alu_a_sel = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd1; e.retire = 1'b1; chk("beq_taken", e); cyc();
    bus.branch_taken = 1'b0;
    fetch("beq2_fetch", 32'hfe7308e3, 3);
    chk("beq2_decode", z(3)); cyc();
    e = z(3); e.alu_a_sel = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; chk("beq_not_taken", e); cyc();
    chk_n("beq_retire", n_ret, 6);
    fetch("jal_fetch", 32'hfedff0ef, 3);
    chk("jal_decode", z(3)); cyc();
    e = z(4); e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1; chk("jal_exec", e); cyc();
    e = z(4); e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; e.wb_sel = 2'd2; e.pc_src = 2'd1;
    chk("jal_wb", e); cyc();
    fetch("lw_fetch", 32'h0003a303, 4);
    bus.imem_ready = 1'b1;
    chk("lw_decode_ignores_imem", z(4)); cyc();
    bus.imem_ready = 1'b0;
    e = z(0); e.alu_b_sel = 1'b1; chk("lw_exec", e); cyc();
    bus.dmem_ready = 1'b1;
    e = z(0); e.dmem_req = 1'b1; chk("lw_mem", e); cyc();
    e = z(0); e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; e.wb_sel = 2'd1; chk("lw_wb_ignores_dmem", e); cyc();
    bus.dmem_ready = 1'b0;
    chk_n("retire_count", n_ret, 8);
    chk_n("pc_we_count", n_pcw, 8);
    fetch("rst_fetch", 32'h0003a303, 0);
    chk("rst_decode", z(0)); cyc();
    e = z(0); e.alu_b_sel = 1'b1; chk("rst_exec", e); cyc();
    e = z(0); e.dmem_req = 1'b1; chk("rst_mem_stall", e);
    rst_n = 1'b0;
    chk("rst_in_mem", z(0)); cyc();
    chk("rst_held", z(0));
    rst_n = 1'b1;
    e = z(0); e.imem_req = 1'b1; chk("rst_refetch", e);
    chk_n("rst_no_retire", n_ret, 8);
    fetch("ill_fetch", 32'h0000007f, 0);
    chk("ill_decode", z(0)); cyc();
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    e = z(0); e.trap = 1'b1; e.trap_cause = 2'd1; chk("ill_trap", e);
    repeat (3) cyc();
    chk("ill_trap_hold", e);
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    e = z(0); e.imem_req = 1'b1; chk("ill_rst_fetch", e);
    repeat (254) cyc();
    chk("imem_wait_255", e);
    cyc();
    e = z(0); e.trap = 1'b1; e.trap_cause = 2'd2; chk("imem_timeout", e);
    cyc();
    chk("imem_timeout_hold", e);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    fetch("dto_fetch", 32'hf863ae23, 0);
    chk("dto_decode", z(0)); cyc();
    e = z(2); e.alu_b_sel = 1'b1; chk("dto_exec", e); cyc();
    repeat (254) cyc();
    e = z(2); e.dmem_req = 1'b1; e.dmem_we = 1'b1; chk("dmem_wait_255", e);
    cyc();
    e = z(2); e.trap = 1'b1; e.trap_cause = 2'd3; chk("dmem_timeout", e);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
